repeated_sub_divider: RTL and testbench
=======================================

REPEATED_SUB_DIVIDER -- requirements
Module: repeated_sub_divider

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits.
REQ-002 clock  input  1  rising-edge clock.
REQ-003 reset  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request a division; sampled on rising edge; accepted only in IDLE.
REQ-005 dividend  input  WIDTH  unsigned dividend; captured on the accepting edge.
REQ-006 divisor  input  WIDTH  unsigned divisor; captured on the accepting edge.
REQ-007 busy  output  1  high in CHECK, SUB and DONE; low in IDLE.
REQ-008 done  output  1  single-cycle pulse, high exactly while in DONE.
REQ-009 quotient  output  WIDTH  registered result; holds until the next DONE.
REQ-010 remainder  output  WIDTH  registered result; holds until the next DONE.
REQ-011 div_by_zero  output  1  registered flag for the last result; holds until the next DONE.

Function
REQ-012 The FSM SHALL have states IDLE, CHECK, SUB and DONE; every other encoding SHALL go to IDLE.
REQ-013 IDLE with start=1: load R<=dividend, D<=divisor, Q<=0, then go to CHECK; with start=0, stay in IDLE.
REQ-014 CHECK: D==0 -> DONE (zero-divide); else R>=D (unsigned) -> SUB; else -> DONE.
REQ-015 SUB: R<=R-D and Q<=Q+1 (WIDTH-bit arithmetic), then go to CHECK.
REQ-016 DONE: unconditionally go to IDLE after one cycle.
REQ-017 On entry to DONE, normal case: quotient<=Q, remainder<=R, div_by_zero<=0.
REQ-018 On entry to DONE, zero-divide case: quotient<=all ones, remainder<=captured dividend, div_by_zero<=1.
REQ-019 Latency: DONE is entered 2q+1 rising edges after the accepting edge, where q is the quotient; zero-divide latency is 1 edge.
REQ-020 The worst case (dividend=2^WIDTH-1, divisor=1) SHALL complete with no overflow of Q.
REQ-021 start while busy=1 (CHECK, SUB or DONE) SHALL be ignored; internal operands SHALL NOT change.
REQ-022 dividend and divisor SHALL be don't-care except on the accepting edge.
REQ-023 Back-to-back operation: the earliest accepting edge is the first edge in IDLE after DONE.

Reset
REQ-024 reset low SHALL force IDLE and clear R, D and Q asynchronously.
REQ-025 reset low SHALL clear busy, done, quotient, remainder and div_by_zero to 0 asynchronously.
REQ-026 Reset mid-operation SHALL abandon the division with no done pulse; the first operation after release behaves as from power-up.

Configuration
REQ-027 With macro REPEATED_SUB_DIVIDER_CYCLE_COUNT_EN defined: add output cycles (input/output direction: output, width 16) holding the edge count from the accepting edge to DONE entry.
REQ-028 cycles SHALL saturate at 16'hFFFF, latch on DONE entry, and reset to 0.
REQ-029 Without REPEATED_SUB_DIVIDER_CYCLE_COUNT_EN: no cycles port and no counter logic; all other behaviour is identical.

Structure
REQ-030 Shared package divider_pkg SHALL hold the state encoding constants (IDLE=2'd0, CHECK=2'd1, SUB=2'd2, DONE=2'd3) and the WIDTH default.
REQ-031 Sub-module rsd_datapath SHALL contain the R, D and Q registers, the subtractor, the R>=D comparator and the D==0 detect.
REQ-032 rsd_datapath SHALL be controlled by load, sub and clear strobes from the top-level FSM.

Verification
REQ-033 100/7 -> quotient=14, remainder=2, div_by_zero=0; done 29 edges after the accepting edge; cycles=29 when the macro is defined.
REQ-034 5/9 -> quotient=0, remainder=5; done 1 edge after the accepting edge.
REQ-035 42/0 -> div_by_zero=1, quotient=255, remainder=42; done 1 edge after the accepting edge.
REQ-036 255/1 -> quotient=255, remainder=0; done 511 edges after the accepting edge; busy high throughout.
REQ-037 200/3 with reset pulsed low during SUB -> all outputs 0 and no done pulse; after release, 200/3 -> quotient=66, remainder=2.
REQ-038 100/7 accepted, then start with 50/5 while busy -> ignored, result 14 r 2; 50/5 issued in IDLE after DONE -> quotient=10, remainder=0.

Source files
------------

// File: rtl/divider_pkg.sv
// ----------------------------------------------------------------------------
// divider_pkg
//   Shared definitions for the repeated-subtraction divider:
//     - state_t         : FSM state encoding (IDLE=0, CHECK=1, SUB=2, DONE=3)
//     - DEFAULT_WIDTH   : default operand/result width
//     - CYCLE_COUNT_WIDTH / sat_inc : width and saturating increment for the
//       optional cycle counter (REPEATED_SUB_DIVIDER_CYCLE_COUNT_EN)
// ----------------------------------------------------------------------------
package divider_pkg;

    localparam int DEFAULT_WIDTH     = 8;
    localparam int CYCLE_COUNT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        SUB   = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CYCLE_COUNT_WIDTH-1:0] sat_inc(
        input logic [CYCLE_COUNT_WIDTH-1:0] value
    );
        if (value == {CYCLE_COUNT_WIDTH{1'b1}}) begin
            return value;
        end
        return value + CYCLE_COUNT_WIDTH'(1);
    endfunction

endpackage

// File: rtl/rsd_datapath.sv
// ----------------------------------------------------------------------------
// rsd_datapath
//   Working registers of the repeated-subtraction divider: remainder R,
//   divisor D and quotient Q, plus the subtractor, the R>=D comparator and
//   the D==0 detect. Driven by strobes from the controlling FSM.
//
//   Ports
//     clock, reset    : rising-edge clock, asynchronous active-low reset
//     load            : R<=dividend, D<=divisor, Q<=0
//     sub             : R<=R-D, Q<=Q+1
//     clear           : R, D, Q <= 0
//     dividend/divisor: operands, used only with load
//     r, q            : current remainder / quotient
//     r_ge_d          : R >= D (unsigned)
//     d_zero          : D == 0
//   Strobe priority: load > sub > clear.
// ----------------------------------------------------------------------------
module rsd_datapath
    import divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             sub,
    input  logic             clear,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] q,
    output logic             r_ge_d,
    output logic             d_zero
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_reg;
    logic [WIDTH-1:0] d_reg;
    logic [WIDTH-1:0] q_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_reg <= '0;
            d_reg <= '0;
            q_reg <= '0;
        end else if (load) begin
            r_reg <= dividend;
            d_reg <= divisor;
            q_reg <= '0;
        end else if (sub) begin
            r_reg <= r_reg - d_reg;
            q_reg <= q_reg + ONE;
        end else if (clear) begin
            r_reg <= '0;
            d_reg <= '0;
            q_reg <= '0;
        end
    end

    assign r      = r_reg;
    assign q      = q_reg;
    assign r_ge_d = (r_reg >= d_reg);
    assign d_zero = (d_reg == '0);

endmodule

// File: rtl/repeated_sub_divider.sv
// ----------------------------------------------------------------------------
// repeated_sub_divider
//   Unsigned divider by repeated subtraction. A start in IDLE captures the
//   operands; the FSM then alternates CHECK/SUB until R < D (or D == 0) and
//   publishes the result with a one-cycle done pulse in DONE.
//   Latency from accepting edge to DONE entry: 2q+1 edges (1 for zero-divide).
//
//   Ports
//     clock, reset      : rising-edge clock, asynchronous active-low reset
//     start             : request; accepted only in IDLE
//     dividend, divisor : operands, sampled on the accepting edge
//     busy              : high in CHECK, SUB, DONE
//     done              : high exactly while in DONE
//     quotient          : result (all ones on divide by zero)
//     remainder         : result (dividend on divide by zero)
//     div_by_zero       : divide-by-zero flag for the last result
//     cycles            : (only with REPEATED_SUB_DIVIDER_CYCLE_COUNT_EN)
//                         edges from accepting edge to DONE entry, saturating
// ----------------------------------------------------------------------------
module repeated_sub_divider
    import divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
`ifdef REPEATED_SUB_DIVIDER_CYCLE_COUNT_EN
    ,
    output logic [CYCLE_COUNT_WIDTH-1:0] cycles
`endif
);

    state_t state_reg;
    state_t state_next;

    logic load;
    logic sub;
    logic clear;
    logic finish;     // this edge enters DONE
    logic zero_div;   // the entry into DONE is a divide-by-zero

    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] q;
    logic             r_ge_d;
    logic             d_zero;

    logic [WIDTH-1:0] quotient_reg;
    logic [WIDTH-1:0] remainder_reg;
    logic             div_by_zero_reg;

    rsd_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clock    (clock),
        .reset    (reset),
        .load     (load),
        .sub      (sub),
        .clear    (clear),
        .dividend (dividend),
        .divisor  (divisor),
        .r        (r),
        .q        (q),
        .r_ge_d   (r_ge_d),
        .d_zero   (d_zero)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        sub        = 1'b0;
        clear      = 1'b0;
        finish     = 1'b0;
        zero_div   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = CHECK;
                end else begin
                    // Park the working registers at zero between divisions.
                    clear = 1'b1;
                end
            end
            CHECK: begin
                if (d_zero) begin
                    finish     = 1'b1;
                    zero_div   = 1'b1;
                    state_next = DONE;
                end else if (r_ge_d) begin
                    state_next = SUB;
                end else begin
                    finish     = 1'b1;
                    state_next = DONE;
                end
            end
            SUB: begin
                sub        = 1'b1;
                state_next = CHECK;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // On divide by zero no SUB has run, so R still holds the captured dividend.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            quotient_reg    <= '0;
            remainder_reg   <= '0;
            div_by_zero_reg <= 1'b0;
        end else if (finish) begin
            quotient_reg    <= zero_div ? {WIDTH{1'b1}} : q;
            remainder_reg   <= r;
            div_by_zero_reg <= zero_div;
        end
    end

    assign busy        = (state_reg != IDLE);
    assign done        = (state_reg == DONE);
    assign quotient    = quotient_reg;
    assign remainder   = remainder_reg;
    assign div_by_zero = div_by_zero_reg;

`ifdef REPEATED_SUB_DIVIDER_CYCLE_COUNT_EN
    // count_reg holds the edges elapsed since the accepting edge; the DONE
    // entry edge itself is added when latching into cycles_reg.
    logic [CYCLE_COUNT_WIDTH-1:0] count_reg;
    logic [CYCLE_COUNT_WIDTH-1:0] cycles_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_reg  <= '0;
            cycles_reg <= '0;
        end else begin
            if (load) begin
                count_reg <= '0;
            end else if (state_reg == CHECK || state_reg == SUB) begin
                count_reg <= sat_inc(count_reg);
            end
            if (finish) begin
                cycles_reg <= sat_inc(count_reg);
            end
        end
    end

    assign cycles = cycles_reg;
`endif

endmodule

// File: tb/tb_repeated_sub_divider.sv
// ----------------------------------------------------------------------------
// tb_repeated_sub_divider
//   Self-checking bench for repeated_sub_divider (WIDTH=8). A vector table is
//   applied in a loop; expected results go into a scoreboard queue when the
//   operation is issued and are compared when done pulses. Hand-written
//   sequences cover start-while-busy and reset mid-operation.
//   Build with +define+REPEATED_SUB_DIVIDER_CYCLE_COUNT_EN to also check cycles.
// ----------------------------------------------------------------------------
module tb_repeated_sub_divider;

    localparam int W = 8;

    logic         clock;
    logic         reset;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
`ifdef REPEATED_SUB_DIVIDER_CYCLE_COUNT_EN
    logic [15:0]  cycles;
`endif

    repeated_sub_divider #(
        .WIDTH (W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
`ifdef REPEATED_SUB_DIVIDER_CYCLE_COUNT_EN
        ,
        .cycles      (cycles)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
    } vec_t;

    typedef struct {
        string        tag;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           acc_edge;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   checks      = 0;
    int   errors      = 0;
    int   edge_cnt    = 0;
    int   done_pulses = 0;

    always @(posedge clock) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor: compare every done pulse against the oldest entry.
    always @(negedge clock) begin
        if (reset && done) begin
            exp_t e;
            done_pulses++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done got done=1 expected no pulse");
            end else begin
                e = sb.pop_front();
                check({e.tag, "_quotient"},    32'(quotient),           32'(e.q));
                check({e.tag, "_remainder"},   32'(remainder),          32'(e.r));
                check({e.tag, "_div_by_zero"}, 32'(div_by_zero),        32'(e.dbz));
                check({e.tag, "_latency"},     32'(edge_cnt - e.acc_edge), 32'(e.lat));
`ifdef REPEATED_SUB_DIVIDER_CYCLE_COUNT_EN
                check({e.tag, "_cycles"},      32'(cycles),             32'(e.lat));
`endif
                $display("op %s: q=%0d r=%0d dbz=%0d latency=%0d", e.tag, quotient,
                         remainder, div_by_zero, edge_cnt - e.acc_edge);
            end
        end
    end

    // Issue one division, push its expectation, wait (bounded) for the result.
    // With poke set, start is held high with 50/5 for the first cycles of the
    // operation to show it is ignored while busy.
    task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input logic edbz,
                         input bit poke);
        exp_t e;
        bit   busy_ok;
        int   n;
        @(negedge clock);
        check({tag, "_idle_before"}, 32'(busy), 32'd0);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clock);
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
        check({tag, "_accepted_busy"}, 32'(busy), 32'd1);
        e.tag      = tag;
        e.q        = eq;
        e.r        = er;
        e.dbz      = edbz;
        e.acc_edge = edge_cnt;
        e.lat      = edbz ? 1 : 2 * int'(eq) + 1;
        sb.push_back(e);
        busy_ok = 1'b1;
        n = 0;
        #1;
        while (sb.size() != 0 && n < 2000) begin
            if (!busy) busy_ok = 1'b0;
            if (poke && n < 10) begin
                start    = 1'b1;
                dividend = 8'd50;
                divisor  = 8'd5;
            end else begin
                start = 1'b0;
            end
            @(negedge clock);
            #1;
            n++;
        end
        start = 1'b0;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout got no done expected done within 2000 cycles", tag);
            sb.delete();
        end
        check({tag, "_busy_throughout"}, 32'(busy_ok), 32'd1);
    endtask

    vec_t vecs[8];

    initial begin
        int saved;
        vecs[0] = '{a: 8'd100, b: 8'd7,   q: 8'd14,  r: 8'd2,  dbz: 1'b0};
        vecs[1] = '{a: 8'd5,   b: 8'd9,   q: 8'd0,   r: 8'd5,  dbz: 1'b0};
        vecs[2] = '{a: 8'd42,  b: 8'd0,   q: 8'd255, r: 8'd42, dbz: 1'b1};
        vecs[3] = '{a: 8'd255, b: 8'd1,   q: 8'd255, r: 8'd0,  dbz: 1'b0};
        vecs[4] = '{a: 8'd0,   b: 8'd5,   q: 8'd0,   r: 8'd0,  dbz: 1'b0};
        vecs[5] = '{a: 8'd7,   b: 8'd7,   q: 8'd1,   r: 8'd0,  dbz: 1'b0};
        vecs[6] = '{a: 8'd13,  b: 8'd255, q: 8'd0,   r: 8'd13, dbz: 1'b0};
        vecs[7] = '{a: 8'd0,   b: 8'd0,   q: 8'd255, r: 8'd0,  dbz: 1'b1};

        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        reset    = 1'b0;
        #12;
        check("reset_busy",        32'(busy),        32'd0);
        check("reset_done",        32'(done),        32'd0);
        check("reset_quotient",    32'(quotient),    32'd0);
        check("reset_remainder",   32'(remainder),   32'd0);
        check("reset_div_by_zero", 32'(div_by_zero), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        for (int i = 0; i < 8; i++) begin
            do_op($sformatf("vec%0d_%0d_div_%0d", i, vecs[i].a, vecs[i].b),
                  vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dbz, 1'b0);
        end

        // Start while busy is ignored; then a normal back-to-back 50/5.
        do_op("busy_poke_100_div_7", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 1'b1);
        do_op("after_poke_50_div_5", 8'd50, 8'd5, 8'd10, 8'd0, 1'b0, 1'b0);

        // Reset during SUB abandons the operation with no done pulse.
        @(negedge clock);
        start    = 1'b1;
        dividend = 8'd200;
        divisor  = 8'd3;
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        saved = done_pulses;
        reset = 1'b0;
        #1;
        check("midreset_busy",        32'(busy),        32'd0);
        check("midreset_done",        32'(done),        32'd0);
        check("midreset_quotient",    32'(quotient),    32'd0);
        check("midreset_remainder",   32'(remainder),   32'd0);
        check("midreset_div_by_zero", 32'(div_by_zero), 32'd0);
`ifdef REPEATED_SUB_DIVIDER_CYCLE_COUNT_EN
        check("midreset_cycles",      32'(cycles),      32'd0);
`endif
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (10) @(negedge clock);
        check("midreset_no_done_pulse", 32'(done_pulses), 32'(saved));
        check("midreset_idle_after",    32'(busy),        32'd0);
        do_op("post_reset_200_div_3", 8'd200, 8'd3, 8'd66, 8'd2, 1'b0, 1'b0);

        repeat (5) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
